// File: rtl/cpc_video_pkg.sv
// Shared types and constants for the CPC gate-array video output decoder:
// level codes, channel intensities, green-screen LUT and default timing.
package cpc_video_pkg;

   typedef logic [1:0] lvl_t;

   localparam lvl_t LVL_OFF  = 2'd0;
   localparam lvl_t LVL_HALF = 2'd1;
   localparam lvl_t LVL_FULL = 2'd2;

   localparam logic [7:0] VAL_OFF  = 8'h00;
   localparam logic [7:0] VAL_HALF = 8'h7F;
   localparam logic [7:0] VAL_FULL = 8'hFF;

   // MONO_LUT[i] = (i*255)/26, truncated
   localparam logic [7:0] MONO_LUT [27] = '{
      8'd0,   8'd9,   8'd19,  8'd29,  8'd39,  8'd49,  8'd58,  8'd68,  8'd78,
      8'd88,  8'd98,  8'd107, 8'd117, 8'd127, 8'd137, 8'd147, 8'd156, 8'd166,
      8'd176, 8'd186, 8'd196, 8'd205, 8'd215, 8'd225, 8'd235, 8'd245, 8'd255
   };

   localparam int H_START_DEF  = 160;
   localparam int H_WIDTH_DEF  = 768;
   localparam int V_START_DEF  = 24;
   localparam int V_HEIGHT_DEF = 272;

   localparam logic [9:0] HCNT_MAX = 10'd1023;
   localparam logic [8:0] VCNT_MAX = 9'd511;

   // A released (tristated) pin floats to mid level through the monitor load
   function automatic lvl_t decode_lvl(input logic oe_n, input logic lvl);
      if (oe_n)     return LVL_HALF;
      else if (lvl) return LVL_FULL;
      else          return LVL_OFF;
   endfunction

   function automatic logic [4:0] mono_idx(input lvl_t r, input lvl_t g, input lvl_t b);
      return 5'(9 * int'(g) + 3 * int'(r) + int'(b));
   endfunction

endpackage

// File: rtl/cpc_video_out_if.sv
// Gate-array video pins in, decoded scaler-facing video out.
// master = gate-array/driver side, slave = decoder.
interface cpc_video_out_if;
   logic       HSYNC;
   logic       VSYNC;
   logic       RED_OE_N;
   logic       RED;
   logic       GREEN_OE_N;
   logic       GREEN;
   logic       BLUE_OE_N;
   logic       BLUE;
   logic       CE_PIX;
   logic [7:0] R;
   logic [7:0] G;
   logic [7:0] B;
   logic       HS;
   logic       VS;
   logic       HBLANK;
   logic       VBLANK;
   logic [9:0] LINE_LEN;

   modport master (
      output HSYNC, VSYNC, RED_OE_N, RED, GREEN_OE_N, GREEN, BLUE_OE_N, BLUE,
      input  CE_PIX, R, G, B, HS, VS, HBLANK, VBLANK, LINE_LEN
   );

   modport slave (
      input  HSYNC, VSYNC, RED_OE_N, RED, GREEN_OE_N, GREEN, BLUE_OE_N, BLUE,
      output CE_PIX, R, G, B, HS, VS, HBLANK, VBLANK, LINE_LEN
   );
endinterface

// File: rtl/cpc_rgb_level.sv
// One colour channel: three-level tristate pin -> level code (combinational)
// and registered 8-bit intensity, with blanking and an override value.
module cpc_rgb_level
   import cpc_video_pkg::*;
(
   input  logic       clk_i,
   input  logic       rst_n_i,
   input  logic       cen_i,
   input  logic       oe_n_i,
   input  logic       lvl_i,
   input  logic       blank_i,
   input  logic       alt_en_i,
   input  logic [7:0] alt_val_i,
   output lvl_t       code_o,
   output logic [7:0] val_o
);

   logic [7:0] val_q, val_d;

   assign code_o = decode_lvl(oe_n_i, lvl_i);

   always_comb begin
      val_d = val_q;
      if (cen_i) begin
         if (blank_i)       val_d = VAL_OFF;
         else if (alt_en_i) val_d = alt_val_i;
         else begin
            case (code_o)
               LVL_HALF: val_d = VAL_HALF;
               LVL_FULL: val_d = VAL_FULL;
               default:  val_d = VAL_OFF;
            endcase
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_n_i) val_q <= VAL_OFF;
      else          val_q <= val_d;
   end

   assign val_o = val_q;

endmodule

// File: rtl/cpc_video_out.sv
// CPC video output stage: RGB decode, sync regeneration, blanking windows and
// line-length measurement. Optional green-screen path: CPC_VIDEO_MONO_EN.
module cpc_video_out
   import cpc_video_pkg::*;
#(
   parameter int H_START  = H_START_DEF,
   parameter int H_WIDTH  = H_WIDTH_DEF,
   parameter int V_START  = V_START_DEF,
   parameter int V_HEIGHT = V_HEIGHT_DEF
) (
   input  logic            clk,
   input  logic            RESET_N,
   input  logic            cen_16,
   input  logic            MONO,
   cpc_video_out_if.slave  vid
);

   localparam logic [10:0] H_LO = 11'(H_START);
   localparam logic [10:0] H_HI = 11'(H_START + H_WIDTH);
   localparam logic [10:0] V_LO = 11'(V_START);
   localparam logic [10:0] V_HI = 11'(V_START + V_HEIGHT);

   logic       hs_q, vs_q, ce_pix_q;
   logic [9:0] hcnt_q, hcnt_d;
   logic [8:0] vcnt_q, vcnt_d;
   logic [9:0] line_len_q, line_len_d;
   logic       hblank_q, hblank_d, vblank_q, vblank_d;
   logic       hs_rise, vs_rise, blank_d;
   lvl_t       r_code, g_code, b_code;
   logic       alt_en;
   logic [7:0] g_alt;
   logic [7:0] r_val, g_val, b_val;

   // hs_q/vs_q double as the previous-sample edge registers and the HS/VS outputs
   assign hs_rise = vid.HSYNC & ~hs_q;
   assign vs_rise = vid.VSYNC & ~vs_q;

   always_comb begin
      hcnt_d     = hcnt_q;
      vcnt_d     = vcnt_q;
      line_len_d = line_len_q;
      if (cen_16) begin
         if (hs_rise) begin
            hcnt_d     = '0;
            line_len_d = (hcnt_q == HCNT_MAX) ? HCNT_MAX : hcnt_q + 10'd1;
         end else if (hcnt_q != HCNT_MAX) begin
            hcnt_d = hcnt_q + 10'd1;
         end
         if (vs_rise)                            vcnt_d = '0;
         else if (hs_rise && vcnt_q != VCNT_MAX) vcnt_d = vcnt_q + 9'd1;
      end
   end

   // Windows use this tick's counter values so blanking lines up with the pixel
   assign hblank_d = !(({1'b0, hcnt_d} >= H_LO) && ({1'b0, hcnt_d} < H_HI));
   assign vblank_d = !(({2'b0, vcnt_d} >= V_LO) && ({2'b0, vcnt_d} < V_HI));
   assign blank_d  = hblank_d | vblank_d;

`ifdef CPC_VIDEO_MONO_EN
   logic [4:0] idx;
   assign idx    = mono_idx(r_code, g_code, b_code);
   assign alt_en = MONO;
   assign g_alt  = MONO_LUT[idx];
`else
   logic unused_mono;
   assign unused_mono = ^{MONO, r_code, g_code, b_code};
   assign alt_en      = 1'b0;
   assign g_alt       = VAL_OFF;
`endif

   cpc_rgb_level u_red (
      .clk_i(clk), .rst_n_i(RESET_N), .cen_i(cen_16),
      .oe_n_i(vid.RED_OE_N), .lvl_i(vid.RED), .blank_i(blank_d),
      .alt_en_i(alt_en), .alt_val_i(VAL_OFF), .code_o(r_code), .val_o(r_val)
   );

   cpc_rgb_level u_green (
      .clk_i(clk), .rst_n_i(RESET_N), .cen_i(cen_16),
      .oe_n_i(vid.GREEN_OE_N), .lvl_i(vid.GREEN), .blank_i(blank_d),
      .alt_en_i(alt_en), .alt_val_i(g_alt), .code_o(g_code), .val_o(g_val)
   );

   cpc_rgb_level u_blue (
      .clk_i(clk), .rst_n_i(RESET_N), .cen_i(cen_16),
      .oe_n_i(vid.BLUE_OE_N), .lvl_i(vid.BLUE), .blank_i(blank_d),
      .alt_en_i(alt_en), .alt_val_i(VAL_OFF), .code_o(b_code), .val_o(b_val)
   );

   always_ff @(posedge clk) begin
      if (!RESET_N) begin
         hs_q       <= 1'b0;
         vs_q       <= 1'b0;
         ce_pix_q   <= 1'b0;
         hcnt_q     <= '0;
         vcnt_q     <= '0;
         line_len_q <= '0;
         hblank_q   <= 1'b1;
         vblank_q   <= 1'b1;
      end else begin
         ce_pix_q   <= cen_16;
         hcnt_q     <= hcnt_d;
         vcnt_q     <= vcnt_d;
         line_len_q <= line_len_d;
         if (cen_16) begin
            hs_q     <= vid.HSYNC;
            vs_q     <= vid.VSYNC;
            hblank_q <= hblank_d;
            vblank_q <= vblank_d;
         end
      end
   end

   assign vid.CE_PIX   = ce_pix_q;
   assign vid.R        = r_val;
   assign vid.G        = g_val;
   assign vid.B        = b_val;
   assign vid.HS       = hs_q;
   assign vid.VS       = vs_q;
   assign vid.HBLANK   = hblank_q;
   assign vid.VBLANK   = vblank_q;
   assign vid.LINE_LEN = line_len_q;

endmodule

// File: tb/tb_cpc_video_out.sv
// Directed bench for cpc_video_out: reset, free-run saturation, line length,
// blank windows, colour decode, simultaneous syncs, mid-line reset.
module tb_cpc_video_out;

   logic clk = 1'b0;
   logic RESET_N;
   logic cen_16;
   logic MONO;

   cpc_video_out_if vif ();

   cpc_video_out dut (
      .clk(clk), .RESET_N(RESET_N), .cen_16(cen_16), .MONO(MONO), .vid(vif)
   );

   always #5 clk = ~clk;

   int          chk_cnt  = 0;
   int          pass_cnt = 0;
   logic        ce_seen;
   logic [23:0] rgb_seen;

   // One cen_16 tick: sample edge, capture the output cycle, then one idle clk
   task automatic tick();
      cen_16 = 1'b1;
      @(posedge clk); #1;
      ce_seen  = vif.CE_PIX;
      rgb_seen = {vif.R, vif.G, vif.B};
      cen_16 = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic hpulse();
      vif.HSYNC = 1'b1;
      tick();
      vif.HSYNC = 1'b0;
   endtask

   // 0 = OFF (driven low), 1 = HALF (released), 2 = FULL (driven high)
   task automatic set_rgb(input int r, input int g, input int b);
      vif.RED_OE_N   = (r == 1); vif.RED   = (r == 2);
      vif.GREEN_OE_N = (g == 1); vif.GREEN = (g == 2);
      vif.BLUE_OE_N  = (b == 1); vif.BLUE  = (b == 2);
   endtask

   task automatic test_reset();
      RESET_N = 1'b0; cen_16 = 1'b0;
      set_rgb(2, 2, 2);
      repeat (4) @(posedge clk);
      #1;
      chk_cnt++; if ({vif.R, vif.G, vif.B} !== 24'h0) $display("FAIL rst_rgb got=%h exp=000000", {vif.R, vif.G, vif.B}); else pass_cnt++;
      chk_cnt++; if ({vif.HS, vif.VS, vif.CE_PIX} !== 3'b000) $display("FAIL rst_sync got=%b exp=000", {vif.HS, vif.VS, vif.CE_PIX}); else pass_cnt++;
      chk_cnt++; if ({vif.HBLANK, vif.VBLANK} !== 2'b11) $display("FAIL rst_blank got=%b exp=11", {vif.HBLANK, vif.VBLANK}); else pass_cnt++;
      chk_cnt++; if (vif.LINE_LEN !== 10'd0) $display("FAIL rst_linelen got=%0d exp=0", vif.LINE_LEN); else pass_cnt++;
      RESET_N = 1'b1;
   endtask

   task automatic test_free_run();
      set_rgb(2, 2, 2);
      for (int i = 1; i <= 1100; i++) begin
         tick();
         if (i == 1) begin
            chk_cnt++; if (ce_seen !== 1'b1 || vif.CE_PIX !== 1'b0) $display("FAIL ce_pix got=%b%b exp=10", ce_seen, vif.CE_PIX); else pass_cnt++;
         end
         if (i == 159) begin
            chk_cnt++; if (vif.HBLANK !== 1'b1) $display("FAIL free_hb159 got=%b exp=1", vif.HBLANK); else pass_cnt++;
         end
         if (i == 160) begin
            chk_cnt++; if (vif.HBLANK !== 1'b0) $display("FAIL free_hb160 got=%b exp=0", vif.HBLANK); else pass_cnt++;
            chk_cnt++; if ({vif.R, vif.G, vif.B} !== 24'h0) $display("FAIL free_vblank_rgb got=%h exp=000000", {vif.R, vif.G, vif.B}); else pass_cnt++;
         end
         if (i == 928) begin
            chk_cnt++; if (vif.HBLANK !== 1'b1) $display("FAIL free_hb928 got=%b exp=1", vif.HBLANK); else pass_cnt++;
         end
      end
      chk_cnt++; if ({vif.VBLANK, vif.HBLANK} !== 2'b11) $display("FAIL free_end_blank got=%b exp=11", {vif.VBLANK, vif.HBLANK}); else pass_cnt++;
      chk_cnt++; if (vif.LINE_LEN !== 10'd0) $display("FAIL free_linelen got=%0d exp=0", vif.LINE_LEN); else pass_cnt++;
   endtask

   task automatic test_line_len();
      hpulse();
      chk_cnt++; if (vif.LINE_LEN !== 10'd1023) $display("FAIL len_sat_first got=%0d exp=1023", vif.LINE_LEN); else pass_cnt++;
      chk_cnt++; if (vif.HS !== 1'b1) $display("FAIL hs_high got=%b exp=1", vif.HS); else pass_cnt++;
      tick();
      chk_cnt++; if (vif.HS !== 1'b0) $display("FAIL hs_low got=%b exp=0", vif.HS); else pass_cnt++;
      run(998);
      hpulse();
      chk_cnt++; if (vif.LINE_LEN !== 10'd1000) $display("FAIL len_1000 got=%0d exp=1000", vif.LINE_LEN); else pass_cnt++;
      run(1023);
      hpulse();
      chk_cnt++; if (vif.LINE_LEN !== 10'd1023) $display("FAIL len_1024_sat got=%0d exp=1023", vif.LINE_LEN); else pass_cnt++;
      for (int i = 1; i <= 930; i++) begin
         tick();
         if (i == 159 || i == 928) begin
            chk_cnt++; if (vif.HBLANK !== 1'b1) $display("FAIL hwin_edge_%0d got=%b exp=1", i, vif.HBLANK); else pass_cnt++;
         end
         if (i == 160 || i == 927) begin
            chk_cnt++; if (vif.HBLANK !== 1'b0) $display("FAIL hwin_in_%0d got=%b exp=0", i, vif.HBLANK); else pass_cnt++;
         end
      end
   endtask

   task automatic test_vblank();
      vif.VSYNC = 1'b1;
      tick();
      chk_cnt++; if ({vif.VS, vif.VBLANK} !== 2'b11) $display("FAIL vs_rise got=%b exp=11", {vif.VS, vif.VBLANK}); else pass_cnt++;
      vif.VSYNC = 1'b0;
      tick();
      chk_cnt++; if (vif.VS !== 1'b0) $display("FAIL vs_low got=%b exp=0", vif.VS); else pass_cnt++;
      for (int n = 1; n <= 296; n++) begin
         hpulse();
         if (n == 23 || n == 296) begin
            chk_cnt++; if (vif.VBLANK !== 1'b1) $display("FAIL vblank_line%0d got=%b exp=1", n, vif.VBLANK); else pass_cnt++;
         end
         if (n == 24 || n == 295) begin
            chk_cnt++; if (vif.VBLANK !== 1'b0) $display("FAIL vactive_line%0d got=%b exp=0", n, vif.VBLANK); else pass_cnt++;
         end
         run(19);
      end
   endtask

   task automatic test_colour();
      int          pr [4] = '{0, 2, 2, 1};
      int          pg [4] = '{0, 2, 1, 1};
      int          pb [4] = '{0, 2, 0, 1};
      logic [23:0] pexp [4] = '{24'h000000, 24'hFFFFFF, 24'hFF7F00, 24'h7F7F7F};
`ifdef CPC_VIDEO_MONO_EN
      MONO = 1'b0;
`else
      MONO = 1'b1;
`endif
      vif.VSYNC = 1'b1; tick(); vif.VSYNC = 1'b0;
      for (int n = 1; n <= 24; n++) begin
         hpulse();
         run(19);
      end
      run(180);
      set_rgb(1, 2, 0);
      tick();
      chk_cnt++; if (rgb_seen !== 24'h7FFF00 || ce_seen !== 1'b1) $display("FAIL colour_mix got=%h/%b exp=7fff00/1", rgb_seen, ce_seen); else pass_cnt++;
      chk_cnt++; if ({vif.R, vif.G, vif.B} !== 24'h7FFF00 || vif.CE_PIX !== 1'b0) $display("FAIL colour_hold got=%h/%b exp=7fff00/0", {vif.R, vif.G, vif.B}, vif.CE_PIX); else pass_cnt++;
      for (int k = 0; k < 4; k++) begin
         set_rgb(pr[k], pg[k], pb[k]);
         tick();
         chk_cnt++; if (rgb_seen !== pexp[k]) $display("FAIL colour_pat%0d got=%h exp=%h", k, rgb_seen, pexp[k]); else pass_cnt++;
      end
      set_rgb(2, 2, 2);
      run(723);
      chk_cnt++; if ({vif.R, vif.G, vif.B} !== 24'hFFFFFF) $display("FAIL colour_h927 got=%h exp=ffffff", {vif.R, vif.G, vif.B}); else pass_cnt++;
      tick();
      chk_cnt++; if ({vif.HBLANK, vif.R, vif.G, vif.B} !== 25'h1000000) $display("FAIL hblank_gate got=%h exp=1000000", {vif.HBLANK, vif.R, vif.G, vif.B}); else pass_cnt++;
   endtask

`ifdef CPC_VIDEO_MONO_EN
   task automatic test_mono();
      int          mr [4] = '{2, 1, 0, 0};
      int          mg [4] = '{2, 1, 0, 2};
      int          mb [4] = '{2, 1, 0, 1};
      logic [23:0] mexp [4] = '{24'h00FF00, 24'h007F00, 24'h000000, 24'h00BA00};
      hpulse();
      run(199);
      MONO = 1'b1;
      for (int k = 0; k < 4; k++) begin
         set_rgb(mr[k], mg[k], mb[k]);
         tick();
         chk_cnt++; if (rgb_seen !== mexp[k]) $display("FAIL mono_pat%0d got=%h exp=%h", k, rgb_seen, mexp[k]); else pass_cnt++;
      end
      MONO = 1'b0;
   endtask
`endif

   task automatic test_same_tick();
      hpulse();
      run(199);
      tick();
      chk_cnt++; if ({vif.HBLANK, vif.VBLANK} !== 2'b00) $display("FAIL same_pre got=%b exp=00", {vif.HBLANK, vif.VBLANK}); else pass_cnt++;
      vif.HSYNC = 1'b1; vif.VSYNC = 1'b1;
      tick();
      vif.HSYNC = 1'b0; vif.VSYNC = 1'b0;
      chk_cnt++; if ({vif.HS, vif.VS, vif.HBLANK, vif.VBLANK} !== 4'b1111) $display("FAIL same_tick got=%b exp=1111", {vif.HS, vif.VS, vif.HBLANK, vif.VBLANK}); else pass_cnt++;
      chk_cnt++; if (vif.LINE_LEN !== 10'd201) $display("FAIL same_linelen got=%0d exp=201", vif.LINE_LEN); else pass_cnt++;
      run(159);
      chk_cnt++; if (vif.HBLANK !== 1'b1) $display("FAIL same_hb159 got=%b exp=1", vif.HBLANK); else pass_cnt++;
      tick();
      chk_cnt++; if (vif.HBLANK !== 1'b0) $display("FAIL same_hb160 got=%b exp=0", vif.HBLANK); else pass_cnt++;
      for (int n = 1; n <= 24; n++) begin
         hpulse();
         if (n == 23) begin
            chk_cnt++; if (vif.VBLANK !== 1'b1) $display("FAIL same_v23 got=%b exp=1", vif.VBLANK); else pass_cnt++;
         end
         if (n == 24) begin
            chk_cnt++; if (vif.VBLANK !== 1'b0) $display("FAIL same_v24 got=%b exp=0", vif.VBLANK); else pass_cnt++;
         end
         run(1);
      end
   endtask

   task automatic test_reset_mid();
      set_rgb(2, 2, 2);
      RESET_N = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk_cnt++; if ({vif.HBLANK, vif.VBLANK, vif.LINE_LEN, vif.R, vif.G, vif.B} !== 36'hC_0000_0000) $display("FAIL mid_rst got=%h exp=c00000000", {vif.HBLANK, vif.VBLANK, vif.LINE_LEN, vif.R, vif.G, vif.B}); else pass_cnt++;
      RESET_N = 1'b1;
      run(159);
      chk_cnt++; if (vif.HBLANK !== 1'b1) $display("FAIL mid_hb159 got=%b exp=1", vif.HBLANK); else pass_cnt++;
      tick();
      chk_cnt++; if ({vif.HBLANK, vif.VBLANK} !== 2'b01) $display("FAIL mid_hb160 got=%b exp=01", {vif.HBLANK, vif.VBLANK}); else pass_cnt++;
   endtask

   initial begin
      RESET_N = 1'b0; cen_16 = 1'b0; MONO = 1'b0;
      vif.HSYNC = 1'b0; vif.VSYNC = 1'b0;
      set_rgb(0, 0, 0);
      test_reset();
      test_free_run();
      test_line_len();
      test_vblank();
      test_colour();
`ifdef CPC_VIDEO_MONO_EN
      test_mono();
`endif
      test_same_tick();
      test_reset_mid();
      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule
